// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, multiply/divide FSM states and default width for alu_seq
package alu_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_NOR   = 4'b0100,
        ALU_SLTU  = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_MULTU = 4'b1000,
        ALU_MULT  = 4'b1001,
        ALU_DIVU  = 4'b1010,
        ALU_DIV   = 4'b1011,
        ALU_MFHI  = 4'b1100,
        ALU_MFLO  = 4'b1101,
        ALU_RSV0  = 4'b1110,
        ALU_RSV1  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_FIX  = 2'd3
    } md_state_e;

    // Op codes 10xx are the iterative multiply/divide group.
    function automatic logic is_md_op(logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - issue/completion handshake and HI/LO bundle between datapath control and alu_seq
interface alu_seq_if import alu_seq_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);

    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             valid;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, input result, zero, valid, busy, hi, lo);
    modport slave  (input start, op, a, b, output result, zero, valid, busy, hi, lo);

endinterface

// File: rtl/alu_seq_md_unit.sv
// rtl/alu_seq_md_unit.sv - iterative shift-add multiplier / restoring divider with sign fix-up state
module md_unit import alu_seq_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             signed_op,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state, state_nx;
    logic [2*WIDTH-1:0] p, p_nx, p_neg;
    logic [WIDTH-1:0]   m, m_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               div_q, div_nx;
    logic               neg_q, neg_q_nx;
    logic               neg_r, neg_r_nx;

    logic               sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum, div_sh, div_diff;

    assign sa    = signed_op & a[WIDTH-1];
    assign sb    = signed_op & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // p holds {accumulator, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
    assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? m : {WIDTH{1'b0}})};
    assign div_sh   = p[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_sh - {1'b0, m};
    assign p_neg    = -p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
            p     <= '0;
            m     <= '0;
            cnt   <= '0;
            div_q <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            state <= state_nx;
            p     <= p_nx;
            m     <= m_nx;
            cnt   <= cnt_nx;
            div_q <= div_nx;
            neg_q <= neg_q_nx;
            neg_r <= neg_r_nx;
        end
    end

    always_comb begin
        state_nx = state;
        p_nx     = p;
        m_nx     = m;
        cnt_nx   = cnt;
        div_nx   = div_q;
        neg_q_nx = neg_q;
        neg_r_nx = neg_r;
        case (state)
            MD_IDLE: begin
                if (go) begin
                    cnt_nx   = '0;
                    div_nx   = is_div;
                    neg_q_nx = sa ^ sb;
                    neg_r_nx = sa;
                    if (is_div && b == '0) begin
                        // Divide by zero: preload the architectural answer and fix up unsigned.
                        p_nx     = {a, {WIDTH{1'b1}}};
                        neg_q_nx = 1'b0;
                        neg_r_nx = 1'b0;
                        state_nx = MD_FIX;
                    end else if (is_div) begin
                        p_nx     = {{WIDTH{1'b0}}, mag_a};
                        m_nx     = mag_b;
                        state_nx = MD_DIV;
                    end else begin
                        p_nx     = {{WIDTH{1'b0}}, mag_b};
                        m_nx     = mag_a;
                        state_nx = MD_MUL;
                    end
                end
            end
            MD_MUL: begin
                p_nx   = {mul_sum, p[WIDTH-1:1]};
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(WIDTH-1)) state_nx = MD_FIX;
            end
            MD_DIV: begin
                p_nx   = {(div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                          p[WIDTH-2:0], ~div_diff[WIDTH]};
                cnt_nx = cnt + 1'b1;
                if (cnt == CW'(WIDTH-1)) state_nx = MD_FIX;
            end
            MD_FIX: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != MD_IDLE);
        done = (state == MD_FIX);
        if (div_q) begin
            hi_out = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
            lo_out = neg_q ? -p[WIDTH-1:0]       : p[WIDTH-1:0];
        end else begin
            hi_out = neg_q ? p_neg[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
            lo_out = neg_q ? p_neg[WIDTH-1:0]       : p[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered MIPS ALU with single-cycle ops, iterative mul/div and HI/LO registers
module alu_seq import alu_seq_pkg::*; #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic  clk,
    input  logic  reset,
    alu_seq_if.slave bus
);

    logic             pend;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             issue, md_go;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_hi, md_lo, alu_out;

    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             zero_q, valid_q;

    // A mul/div waiting in the issue register already counts as busy so no issue slips in behind it.
    assign md_go    = pend & is_md_op(op_q);
    assign bus.busy = md_busy | md_go;
    assign issue    = bus.start & ~bus.busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            pend <= issue;
            if (issue) begin
                op_q <= bus.op;
                a_q  <= bus.a;
                b_q  <= bus.b;
            end
        end
    end

    md_unit #(.WIDTH(WIDTH)) u_md (
        .clk       (clk),
        .reset     (reset),
        .go        (md_go),
        .signed_op (op_q[0]),
        .is_div    (op_q[1]),
        .a         (a_q),
        .b         (b_q),
        .busy      (md_busy),
        .done      (md_done),
        .hi_out    (md_hi),
        .lo_out    (md_lo)
    );

    always_comb begin
        alu_out = '0;
        case (alu_op_e'(op_q))
            ALU_AND:  alu_out = a_q & b_q;
            ALU_OR:   alu_out = a_q | b_q;
            ALU_ADD:  alu_out = a_q + b_q;
            ALU_XOR:  alu_out = a_q ^ b_q;
            ALU_NOR:  alu_out = ~(a_q | b_q);
            ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            ALU_SUB:  alu_out = a_q - b_q;
            ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_MFHI: alu_out = hi_q;
            ALU_MFLO: alu_out = lo_q;
            default:  alu_out = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            valid_q <= 1'b0;
            if (md_done) begin
                hi_q     <= md_hi;
                lo_q     <= md_lo;
                result_q <= md_lo;
                zero_q   <= (md_lo == '0);
                valid_q  <= 1'b1;
            end else if (pend && !is_md_op(op_q)) begin
                result_q <= alu_out;
                zero_q   <= (alu_out == '0);
                valid_q  <= 1'b1;
            end
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.valid  = valid_q;
    assign bus.hi     = hi_q;
    assign bus.lo     = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq at WIDTH 32 and 8
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) b32();
    alu_seq_if #(.WIDTH(8))  b8();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    function automatic logic [31:0] ref_single(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return m_hi;
            4'd13: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    task automatic ref_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'h0;
        lo = 32'h0;
        if (op == 4'd8) begin
            p = {32'h0, a} * {32'h0, b};
            hi = p[63:32]; lo = p[31:0];
        end else if (op == 4'd9) begin
            p = sa * sb;
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 32'h0) begin
            lo = 32'hFFFF_FFFF; hi = a;
        end else if (op == 4'd10) begin
            lo = a / b; hi = a % b;
        end else begin
            q = sa / sb; r = sa % sb;
            t = q; lo = t[31:0];
            t = r; hi = t[31:0];
        end
    endtask

    task automatic run32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic z, output int lat);
        @(negedge clk);
        b32.start = 1'b1; b32.op = op; b32.a = a; b32.b = b;
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0; b32.a = $urandom; b32.b = $urandom;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (b32.valid) break;
        end
        res = b32.result;
        z   = b32.zero;
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
        @(negedge clk);
        b8.start = 1'b1; b8.op = op; b8.a = a; b8.b = b;
        @(posedge clk);
        @(negedge clk);
        b8.start = 1'b0; b8.a = 8'($urandom); b8.b = 8'($urandom);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (b8.valid) break;
        end
        res = b8.result;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b32.start = 1'b0; b32.op = 4'd0; b32.a = 32'h0; b32.b = 32'h0;
        b8.start = 1'b0;  b8.op = 4'd0;  b8.a = 8'h0;   b8.b = 8'h0;
        repeat (2) @(negedge clk);
        checks++; if (b32.result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", b32.result); end
        checks++; if (b32.zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", b32.zero); end
        checks++; if (b32.valid !== 1'b0 || b32.busy !== 1'b0) begin failures++; $display("FAIL reset_valid_busy got=%b%b exp=00", b32.valid, b32.busy); end
        checks++; if (b32.hi !== 32'h0 || b32.lo !== 32'h0) begin failures++; $display("FAIL reset_hilo got=%h/%h exp=0/0", b32.hi, b32.lo); end
        checks++; if (b8.zero !== 1'b1 || b8.result !== 8'h0) begin failures++; $display("FAIL reset_w8 got=%b/%h exp=1/00", b8.zero, b8.result); end
        reset = 1'b0;
    endtask

    task automatic test_single();
        logic [3:0]  ops[9]  = '{4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd6, 4'd0, 4'd3, 4'd14};
        logic [31:0] as[9]   = '{32'd64, 32'd300, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd1};
        logic [31:0] bs[9]   = '{32'd72, 32'd400, 32'd1, 32'd1, 32'd0, 32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'd2};
        logic [31:0] exps[9] = '{32'd136, 32'hFFFFFF9C, 32'd1, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hF000F000, 32'h0FF00FF0, 32'd0};
        logic [31:0] res;
        logic z;
        int lat;
        for (int i = 0; i < 9; i++) begin
            run32(ops[i], as[i], bs[i], res, z, lat);
            checks++; if (res !== exps[i]) begin failures++; $display("FAIL single_result[%0d] got=%h exp=%h", i, res, exps[i]); end
            checks++; if (z !== (exps[i] == 32'd0)) begin failures++; $display("FAIL single_zero[%0d] got=%b exp=%b", i, z, exps[i] == 32'd0); end
            checks++; if (lat !== 1) begin failures++; $display("FAIL single_latency[%0d] got=%0d exp=1", i, lat); end
        end
        checks++; if (b32.hi !== m_hi || b32.lo !== m_lo) begin failures++; $display("FAIL reserved_hilo got=%h/%h exp=%h/%h", b32.hi, b32.lo, m_hi, m_lo); end
    endtask

    task automatic test_md_directed();
        logic [3:0]  ops[6] = '{4'd9, 4'd8, 4'd11, 4'd10, 4'd11, 4'd10};
        logic [31:0] as[6]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd400, 32'h80000000, 32'd9};
        logic [31:0] bs[6]  = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd72, 32'hFFFFFFFF, 32'd0};
        logic [31:0] ehi[6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd40, 32'd0, 32'd9};
        logic [31:0] elo[6] = '{32'hFFFFFFEB, 32'h00000001, 32'hFFFFFFFD, 32'd5, 32'h80000000, 32'hFFFFFFFF};
        int          elat[6] = '{34, 34, 34, 34, 34, 2};
        logic [31:0] res;
        logic z;
        int lat;
        for (int i = 0; i < 6; i++) begin
            run32(ops[i], as[i], bs[i], res, z, lat);
            checks++; if (lat !== elat[i]) begin failures++; $display("FAIL md_latency[%0d] got=%0d exp=%0d", i, lat, elat[i]); end
            checks++; if (b32.hi !== ehi[i] || b32.lo !== elo[i]) begin failures++; $display("FAIL md_hilo[%0d] got=%h/%h exp=%h/%h", i, b32.hi, b32.lo, ehi[i], elo[i]); end
            checks++; if (res !== elo[i] || b32.busy !== 1'b0) begin failures++; $display("FAIL md_result_busy[%0d] got=%h/%b exp=%h/0", i, res, b32.busy, elo[i]); end
            m_hi = ehi[i]; m_lo = elo[i];
            @(negedge clk);
            checks++; if (b32.valid !== 1'b0) begin failures++; $display("FAIL md_single_pulse[%0d] got=%b exp=0", i, b32.valid); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a, b, ehi, elo;
        int lat;
        a = $urandom; b = $urandom;
        ref_md(4'd8, a, b, ehi, elo);
        @(negedge clk);
        b32.start = 1'b1; b32.op = 4'd8; b32.a = a; b32.b = b;
        @(posedge clk);
        @(negedge clk);
        b32.op = 4'd2; b32.a = $urandom; b32.b = $urandom;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                checks++; if (b32.busy !== 1'b1) begin failures++; $display("FAIL busy_during_mul got=%b exp=1", b32.busy); end
            end
            if (b32.valid) break;
        end
        checks++; if (lat !== 34) begin failures++; $display("FAIL busy_ignore_latency got=%0d exp=34", lat); end
        checks++; if (b32.lo !== elo || b32.hi !== ehi || b32.result !== elo) begin failures++; $display("FAIL busy_ignore_hilo got=%h/%h/%h exp=%h/%h", b32.hi, b32.lo, b32.result, ehi, elo); end
        m_hi = ehi; m_lo = elo;
        b32.op = 4'd13;
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0;
        checks++; if (b32.valid !== 1'b0) begin failures++; $display("FAIL mflo_gap_valid got=%b exp=0", b32.valid); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (b32.valid !== 1'b1 || b32.result !== elo) begin failures++; $display("FAIL mflo_on_valid got=%b/%h exp=1/%h", b32.valid, b32.result, elo); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pick[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12, 4'd13};
        logic [31:0] exp_q[$];
        logic [31:0] a, b, e;
        logic [3:0]  op;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = exp_q.pop_front();
                checks++; if (b32.valid !== 1'b1 || b32.result !== e || b32.zero !== (e == 32'd0)) begin failures++; $display("FAIL b2b[%0d] got=%b/%h/%b exp=1/%h/%b", i - 2, b32.valid, b32.result, b32.zero, e, e == 32'd0); end
            end
            if (i < 20) begin
                op = pick[$urandom_range(9)];
                a = $urandom; b = (i % 5 == 0) ? a : $urandom;
                exp_q.push_back(ref_single(op, a, b));
                b32.start = 1'b1; b32.op = op; b32.a = a; b32.b = b;
            end else begin
                b32.start = 1'b0;
            end
        end
    endtask

    task automatic test_random_md();
        logic [3:0]  op;
        logic [31:0] a, b, ehi, elo, res;
        logic z;
        int lat, elat;
        for (int k = 0; k < 12; k++) begin
            op = 4'(8 + $urandom_range(3));
            a = $urandom; b = $urandom;
            if (k % 4 == 3) begin op = 4'(10 + (k % 2)); b = 32'd0; end
            if (k == 5) begin op = 4'd11; a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (k == 6) b = 32'($urandom_range(1, 9)) | ((k % 2 == 0) ? 32'h80000000 : 32'h0);
            ref_md(op, a, b, ehi, elo);
            elat = (op[1] && b == 32'd0) ? 2 : 34;
            run32(op, a, b, res, z, lat);
            checks++; if (lat !== elat) begin failures++; $display("FAIL rnd_md_latency[%0d] got=%0d exp=%0d", k, lat, elat); end
            checks++; if (b32.hi !== ehi || b32.lo !== elo) begin failures++; $display("FAIL rnd_md_hilo[%0d] op=%0d a=%h b=%h got=%h/%h exp=%h/%h", k, op, a, b, b32.hi, b32.lo, ehi, elo); end
            checks++; if (res !== elo || z !== (elo == 32'd0)) begin failures++; $display("FAIL rnd_md_result[%0d] got=%h/%b exp=%h", k, res, z, elo); end
            m_hi = ehi; m_lo = elo;
        end
    endtask

    task automatic test_reset_mid_mult();
        logic [31:0] a, b, res;
        logic z;
        int lat, vcount;
        @(negedge clk);
        b32.start = 1'b1; b32.op = 4'd9; b32.a = $urandom | 32'h1; b32.b = $urandom | 32'h1;
        @(posedge clk);
        @(negedge clk);
        b32.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (b32.result !== 32'h0 || b32.zero !== 1'b1) begin failures++; $display("FAIL midreset_result got=%h/%b exp=0/1", b32.result, b32.zero); end
        checks++; if (b32.busy !== 1'b0 || b32.valid !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b/%b exp=0/0", b32.busy, b32.valid); end
        checks++; if (b32.hi !== 32'h0 || b32.lo !== 32'h0) begin failures++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", b32.hi, b32.lo); end
        m_hi = 32'h0; m_lo = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (b32.valid) vcount++;
        end
        checks++; if (vcount !== 0) begin failures++; $display("FAIL midreset_no_valid got=%0d exp=0", vcount); end
        a = $urandom; b = $urandom;
        run32(4'd2, a, b, res, z, lat);
        checks++; if (res !== a + b || lat !== 1) begin failures++; $display("FAIL midreset_add got=%h lat=%0d exp=%h lat=1", res, lat, a + b); end
    endtask

    task automatic test_width8();
        logic [7:0] res;
        int lat;
        run8(4'd8, 8'hFF, 8'hFF, res, lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL w8_multu_latency got=%0d exp=10", lat); end
        checks++; if (b8.hi !== 8'hFE || b8.lo !== 8'h01 || res !== 8'h01) begin failures++; $display("FAIL w8_multu got=%h/%h/%h exp=fe/01/01", b8.hi, b8.lo, res); end
        run8(4'd11, 8'h80, 8'h03, res, lat);
        checks++; if (lat !== 10) begin failures++; $display("FAIL w8_div_latency got=%0d exp=10", lat); end
        checks++; if (b8.hi !== 8'hFE || b8.lo !== 8'hD6 || res !== 8'hD6) begin failures++; $display("FAIL w8_div got=%h/%h/%h exp=fe/d6/d6", b8.hi, b8.lo, res); end
        run8(4'd10, 8'h09, 8'h00, res, lat);
        checks++; if (lat !== 2 || b8.hi !== 8'h09 || b8.lo !== 8'hFF) begin failures++; $display("FAIL w8_divzero got=%0d/%h/%h exp=2/09/ff", lat, b8.hi, b8.lo); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_md_directed();
        test_busy_ignore();
        test_back_to_back();
        test_random_md();
        test_reset_mid_mult();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
